// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and a 2*WIDTH accumulator.
// Define ALU_MULT_EN to build the multi-cycle shift-add multiplier for op 010.
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 use_acc,
   input  logic                 acc_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic [2*WIDTH-1:0]   acc,
   output logic                 busy
);

   localparam int N = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             load;
   logic [N-1:0]     load_val;
   logic [N-1:0]     alu_res;
   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   assign opb  = use_acc ? acc[WIDTH-1:0] : b;
   assign sum  = {1'b0, a} + {1'b0, opb};
   assign diff = {1'b0, a} - {1'b0, opb};

   always_comb begin
      alu_res = '0;
      unique case (op)
         3'b000:  alu_res = {{(N-WIDTH-1){1'b0}}, sum};
         3'b001:  alu_res = {{(N-WIDTH-1){1'b0}}, diff};
         3'b011:  alu_res = {a | opb, a ^ opb};
         3'b100:  alu_res[0] = |{a, opb};
         3'b101:  alu_res[0] = &{a, opb};
         3'b110:  alu_res = {a, opb};
         // shifting by N or more already yields zero
         3'b111:  alu_res = acc << opb;
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_MULT_EN
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt;
   logic [N-1:0]     mcand;
   logic [N-1:0]     prod;
   logic [N-1:0]     prod_nxt;
   logic [WIDTH-1:0] mplier;

   assign prod_nxt = mplier[0] ? prod + mcand : prod;
   assign busy     = (state == BUSY);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
      end else if (accept && op == 3'b010) begin
         cnt    <= CW'(WIDTH);
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= opb;
         prod   <= '0;
      end else if (state == BUSY) begin
         cnt    <= cnt - CW'(1);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         prod   <= prod_nxt;
      end
   end
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_val  = alu_res;
      unique case (state)
         IDLE: begin
            if (accept) begin
`ifdef ALU_MULT_EN
               if (op == 3'b010) begin
                  state_nxt = BUSY;
               end else begin
                  state_nxt = DONE;
                  load      = 1'b1;
               end
`else
               state_nxt = DONE;
               load      = 1'b1;
`endif
            end
         end
         BUSY: begin
`ifdef ALU_MULT_EN
            // last partial product goes straight into result
            if (cnt == CW'(1)) begin
               state_nxt = DONE;
               load      = 1'b1;
               load_val  = prod_nxt;
            end
`else
            state_nxt = IDLE;
`endif
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state  <= IDLE;
         result <= '0;
         acc    <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            result <= load_val;
         end
         if (acc_clr) begin
            acc <= '0;
         end else if (load) begin
            acc <= load_val;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, hand sequences and random ops against a model.
// Expectations follow ALU_MULT_EN when it is defined for the build.
module tb_alu_seq;

   localparam int W = 4;
   localparam int N = 2 * W;
`ifdef ALU_MULT_EN
   localparam bit MULT = 1'b1;
`else
   localparam bit MULT = 1'b0;
`endif

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ua;
      logic [N-1:0] exp;
   } vec_t;

   logic         clock = 1'b0;
   logic         resetn;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         use_acc;
   logic         acc_clr;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic [N-1:0] acc;
   logic         busy;

   int           vectors = 0;
   int           miscompares = 0;
   logic [N-1:0] m_acc;

   alu_seq #(.WIDTH(W)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .use_acc   (use_acc),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .acc       (acc),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Arithmetic reference: x = A, y = selected B, ac = accumulator.
   function automatic logic [N-1:0] model(input int o, input int x,
                                          input int y, input int ac);
      int r;
      int m;
      m = 1 << W;
      case (o)
         0: r = x + y;
         1: r = (x >= y) ? x - y : x - y + 2 * m;
         2: r = MULT ? x * y : 0;
         3: r = (x | y) * m + (x ^ y);
         4: r = (x != 0 || y != 0) ? 1 : 0;
         5: r = (x == m - 1 && y == m - 1) ? 1 : 0;
         6: r = x * m + y;
         default: r = (y >= N) ? 0 : ((ac << y) & ((1 << N) - 1));
      endcase
      return r[N-1:0];
   endfunction

   task automatic run_op(input string nm, input logic [2:0] o,
                         input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic ua, input logic clr, input int hold,
                         input logic [N-1:0] exp);
      int           lat;
      logic [N-1:0] exp_acc;
      lat     = (MULT && o == 3'b010) ? W + 1 : 1;
      exp_acc = clr ? '0 : exp;
      chk({nm, " idle in_ready"}, 32'(in_ready), 32'(1));
      in_valid = 1'b1;
      op       = o;
      a        = ai;
      b        = bi;
      use_acc  = ua;
      acc_clr  = clr && (lat == 1);
      for (int j = 1; j <= lat; j++) begin
         @(negedge clock);
         in_valid = 1'b0;
         op       = 3'($urandom);
         a        = W'($urandom);
         b        = W'($urandom);
         use_acc  = 1'($urandom);
         acc_clr  = clr && (j == lat - 1);
         chk({nm, " out_valid"}, 32'(out_valid), 32'(j == lat));
         chk({nm, " in_ready"}, 32'(in_ready), 32'(0));
         chk({nm, " busy"}, 32'(busy), 32'(lat > 1 && j < lat));
      end
      chk({nm, " result"}, 32'(result), 32'(exp));
      chk({nm, " acc"}, 32'(acc), 32'(exp_acc));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         op       = 3'b000;
         a        = W'(1);
         b        = W'(1);
         @(negedge clock);
         chk({nm, " hold out_valid"}, 32'(out_valid), 32'(1));
         chk({nm, " hold in_ready"}, 32'(in_ready), 32'(0));
         chk({nm, " hold result"}, 32'(result), 32'(exp));
         chk({nm, " hold acc"}, 32'(acc), 32'(exp_acc));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk({nm, " release in_ready"}, 32'(in_ready), 32'(1));
      chk({nm, " release out_valid"}, 32'(out_valid), 32'(0));
      m_acc = exp_acc;
   endtask

   initial begin
      vec_t         tbl[16];
      logic [N-1:0] e;
      logic [2:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         ru;
      logic         rc;
      int           rh;

      resetn    = 1'b0;
      in_valid  = 1'b0;
      op        = 3'b000;
      a         = '0;
      b         = '0;
      use_acc   = 1'b0;
      acc_clr   = 1'b0;
      out_ready = 1'b0;
      m_acc     = '0;

      repeat (2) @(negedge clock);
      chk("reset result", 32'(result), 32'(0));
      chk("reset acc", 32'(acc), 32'(0));
      chk("reset out_valid", 32'(out_valid), 32'(0));
      chk("reset busy", 32'(busy), 32'(0));
      resetn = 1'b1;
      @(negedge clock);
      chk("reset in_ready", 32'(in_ready), 32'(1));

      tbl[0]  = '{3'b000, 4'h9, 4'h8, 1'b0, 8'h11};
      tbl[1]  = '{3'b000, 4'h1, 4'h0, 1'b1, 8'h02};
      tbl[2]  = '{3'b001, 4'h3, 4'h5, 1'b0, 8'h1E};
      tbl[3]  = '{3'b011, 4'hA, 4'h6, 1'b0, 8'hEC};
      tbl[4]  = '{3'b111, 4'h0, 4'h2, 1'b0, 8'hB0};
      tbl[5]  = '{3'b110, 4'h3, 4'h4, 1'b0, 8'h34};
      tbl[6]  = '{3'b100, 4'h0, 4'h0, 1'b0, 8'h00};
      tbl[7]  = '{3'b100, 4'h0, 4'h1, 1'b0, 8'h01};
      tbl[8]  = '{3'b101, 4'hF, 4'hF, 1'b0, 8'h01};
      tbl[9]  = '{3'b101, 4'hF, 4'hE, 1'b0, 8'h00};
      tbl[10] = '{3'b000, 4'hF, 4'hF, 1'b0, 8'h1E};
      tbl[11] = '{3'b111, 4'h0, 4'h8, 1'b0, 8'h00};
      tbl[12] = '{3'b001, 4'h5, 4'h5, 1'b0, 8'h00};
      tbl[13] = '{3'b001, 4'h0, 4'hF, 1'b0, 8'h11};
      tbl[14] = '{3'b010, 4'hF, 4'hF, 1'b0, MULT ? 8'hE1 : 8'h00};
      tbl[15] = '{3'b010, 4'h0, 4'h9, 1'b0, 8'h00};
      for (int i = 0; i < 16; i++) begin
         run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].ua, 1'b0, 0, tbl[i].exp);
      end

      run_op("backpressure", 3'b000, 4'h9, 4'h8, 1'b0, 1'b0, 3, 8'h11);
      run_op("acc_add", 3'b000, 4'h1, 4'h0, 1'b1, 1'b0, 0, 8'h02);
      run_op("acc_shl", 3'b111, 4'h0, 4'h2, 1'b0, 1'b0, 0, 8'h08);
      run_op("acc_clr", 3'b000, 4'h2, 4'h3, 1'b0, 1'b1, 1, 8'h05);
      run_op("mul_clr", 3'b010, 4'h7, 4'h3, 1'b0, 1'b1, 0,
             MULT ? 8'h15 : 8'h00);
      run_op("mul_acc", 3'b010, 4'h3, 4'h0, 1'b1, 1'b0, 0, 8'h00);
      run_op("pre_rst", 3'b000, 4'h5, 4'h6, 1'b0, 1'b0, 0, 8'h0B);

      in_valid = 1'b1;
      op       = 3'b010;
      a        = 4'hF;
      b        = 4'hF;
      use_acc  = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      chk("midrst out_valid", 32'(out_valid), 32'(0));
      chk("midrst result", 32'(result), 32'(0));
      chk("midrst acc", 32'(acc), 32'(0));
      chk("midrst busy", 32'(busy), 32'(0));
      chk("midrst in_ready", 32'(in_ready), 32'(1));
      m_acc = '0;
      run_op("post_rst", 3'b110, 4'h3, 4'h4, 1'b0, 1'b0, 0, 8'h34);

      for (int i = 0; i < 150; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = W'($urandom);
         rb = W'($urandom);
         ru = 1'($urandom_range(0, 1));
         rc = ($urandom_range(0, 7) == 0);
         rh = $urandom_range(0, 2);
         e  = model(int'(ro), int'(ra),
                    int'(ru ? m_acc[W-1:0] : rb), int'(m_acc));
         run_op("rnd", ro, ra, rb, ru, rc, rh, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
